// File: rtl/ili9341_pkg.sv
// ----------------------------------------------------------------------------
// ili9341_pkg
// Shared definitions for the ILI9341 test-pattern source:
//   mode_t    - pattern selector encodings (solid, bars, checker, gradient)
//   state_t   - frame sequencer states
//   RGB565_*  - named colour constants
//   bar_color - colour-bar lookup, index 0..7 left to right
// ----------------------------------------------------------------------------
package ili9341_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB565_RED     = 16'hF800;
    localparam logic [15:0] RGB565_BLUE    = 16'h001F;
    localparam logic [15:0] RGB565_BLACK   = 16'h0000;

    // Classic SMPTE-like ordering; bars beyond the eighth repeat the table.
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB565_WHITE;
            3'd1:    return RGB565_YELLOW;
            3'd2:    return RGB565_CYAN;
            3'd3:    return RGB565_GREEN;
            3'd4:    return RGB565_MAGENTA;
            3'd5:    return RGB565_RED;
            3'd6:    return RGB565_BLUE;
            default: return RGB565_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/ili9341_pattern_source_if.sv
// ----------------------------------------------------------------------------
// ili9341_pattern_source_if
// Pixel stream between the pattern source (master) and ili9341_controller
// (slave).
//   pixel_valid  master->slave  pixel_data/x/y carry a valid pixel
//   pixel_ready  slave->master  consumer takes the pixel this cycle
//   pixel_data   master->slave  pixel colour
//   pixel_x/y    master->slave  raster coordinates of pixel_data
//   frame_start  master->slave  current pixel is (0,0)
//   frame_done   master->slave  level, high once a single-shot frame is done
// ----------------------------------------------------------------------------
interface ili9341_pattern_source_if #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int PIXEL_SIZE = 16
);

    logic                     pixel_valid;
    logic                     pixel_ready;
    logic [PIXEL_SIZE-1:0]    pixel_data;
    logic [$clog2(H_RES)-1:0] pixel_x;
    logic [$clog2(V_RES)-1:0] pixel_y;
    logic                     frame_start;
    logic                     frame_done;

    modport master (
        output pixel_valid, pixel_data, pixel_x, pixel_y, frame_start, frame_done,
        input  pixel_ready
    );

    modport slave (
        input  pixel_valid, pixel_data, pixel_x, pixel_y, frame_start, frame_done,
        output pixel_ready
    );

endinterface

// File: rtl/ili9341_pattern_gen.sv
// ----------------------------------------------------------------------------
// ili9341_pattern_gen
// Purely combinational colour generator: maps a raster position and the
// frame's latched settings to one pixel.
//   mode     in  pattern selector (mode_t)
//   color    in  latched colour for solid / checker
//   x, y     in  raster coordinates
//   bar_idx  in  colour-bar index of column x (supplied by the caller's counter)
//   pixel    out generated colour, PIXEL_SIZE bits
// ----------------------------------------------------------------------------
module ili9341_pattern_gen
    import ili9341_pkg::*;
#(
    parameter int PIXEL_SIZE  = 16,
    parameter int CHECK_SHIFT = 4,
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int BAR_W       = 3
) (
    input  mode_t                 mode,
    input  logic [PIXEL_SIZE-1:0] color,
    input  logic [X_W-1:0]        x,
    input  logic [Y_W-1:0]        y,
    input  logic [BAR_W-1:0]      bar_idx,
    output logic [PIXEL_SIZE-1:0] pixel
);

    localparam int SUM_W = ((X_W > Y_W) ? X_W : Y_W) + 1;

    logic [15:0]           bar_565;
    logic [PIXEL_SIZE-1:0] bar_px;
    logic [SUM_W-1:0]      grad_sum;

    // Casting to 3 bits gives "index mod 8" for wide indices and zero-extends narrow ones.
    assign bar_565  = bar_color(3'(bar_idx));
    assign grad_sum = SUM_W'(x) + SUM_W'(y);

    // Narrow pixels keep the most significant RGB565 bits; wide pixels zero-extend.
    generate
        if (PIXEL_SIZE >= 16) begin : g_bar_wide
            assign bar_px = PIXEL_SIZE'(bar_565);
        end else begin : g_bar_narrow
            assign bar_px = bar_565[15 -: PIXEL_SIZE];
        end
    endgenerate

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        pixel = color;
        case (mode)
            MODE_SOLID: pixel = color;
            MODE_BARS:  pixel = bar_px;
            MODE_CHECK: pixel = (x[CHECK_SHIFT] ^ y[CHECK_SHIFT]) ? ~color : color;
            MODE_GRAD:  pixel = PIXEL_SIZE'(grad_sum);
            default:    pixel = color;
        endcase
    end

endmodule

// File: rtl/ili9341_pattern_source.sv
// ----------------------------------------------------------------------------
// ili9341_pattern_source
// Streams full frames of test patterns in raster order over a valid/ready
// pixel interface, single-shot or continuous.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   start        in   begin a frame (honoured only when not running)
//   continuous   in   restart after the frame; sampled on the last-pixel accept
//   mode         in   0 solid, 1 bars, 2 checker, 3 gradient; latched per frame
//   solid_color  in   colour for solid / checker; latched per frame
//   pix          master modport: pixel_valid/ready/data/x/y, frame_start, frame_done
//   busy         out  high while a frame is being streamed
// H_RES must be a multiple of BAR_COUNT.
// ----------------------------------------------------------------------------
module ili9341_pattern_source
    import ili9341_pkg::*;
#(
    parameter int H_RES       = 320,
    parameter int V_RES       = 240,
    parameter int PIXEL_SIZE  = 16,
    parameter int CHECK_SHIFT = 4,
    parameter int BAR_COUNT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [1:0]            mode,
    input  logic [PIXEL_SIZE-1:0] solid_color,
    ili9341_pattern_source_if.master pix,
    output logic                  busy
);

    localparam int X_W     = $clog2(H_RES);
    localparam int Y_W     = $clog2(V_RES);
    localparam int BAR_PIX = H_RES / BAR_COUNT;
    localparam int BAR_W   = (BAR_COUNT > 1) ? $clog2(BAR_COUNT) : 1;
    localparam int BC_W    = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;

    // Registered state
    state_t                state;
    mode_t                 mode_q;
    logic [PIXEL_SIZE-1:0] color_q;
    logic [X_W-1:0]        x_q;
    logic [Y_W-1:0]        y_q;
    logic [BC_W-1:0]       bar_cnt_q;
    logic [BAR_W-1:0]      bar_idx_q;
    logic                  valid_q;
    logic [PIXEL_SIZE-1:0] data_q;
    logic                  frame_start_q;
    logic                  frame_done_q;
    logic                  busy_q;

    // Next-pixel values: the pattern generator looks at these so that the
    // colour is registered together with the coordinates it belongs to.
    mode_t                 mode_n;
    logic [PIXEL_SIZE-1:0] color_n;
    logic [X_W-1:0]        x_n;
    logic [Y_W-1:0]        y_n;
    logic [BC_W-1:0]       bar_cnt_n;
    logic [BAR_W-1:0]      bar_idx_n;
    logic [PIXEL_SIZE-1:0] gen_pixel;

    logic accept;
    logic last_col;
    logic last_px;
    logic launch;
    logic wrap;
    logic reload;
    logic advance;

    always_comb begin
        accept   = valid_q & pix.pixel_ready;
        last_col = (x_q == X_W'(H_RES - 1));
        last_px  = last_col && (y_q == Y_W'(V_RES - 1));
        launch   = (state != ST_RUN) && start;
        wrap     = accept && last_px && continuous;
        reload   = launch || wrap;
        advance  = accept && !last_px;

        mode_n    = mode_q;
        color_n   = color_q;
        x_n       = x_q;
        y_n       = y_q;
        bar_cnt_n = bar_cnt_q;
        bar_idx_n = bar_idx_q;

        if (reload) begin
            // New frame: settings are captured here and nowhere else, so
            // mid-frame changes on mode/solid_color wait for the next frame.
            mode_n    = mode_t'(mode);
            color_n   = solid_color;
            x_n       = '0;
            y_n       = '0;
            bar_cnt_n = '0;
            bar_idx_n = '0;
        end else if (advance) begin
            if (last_col) begin
                x_n       = '0;
                y_n       = y_q + 1'b1;
                bar_cnt_n = '0;
                bar_idx_n = '0;
            end else begin
                x_n = x_q + 1'b1;
                // Bar sub-counter replaces a divide of x by the bar width.
                if (bar_cnt_q == BC_W'(BAR_PIX - 1)) begin
                    bar_cnt_n = '0;
                    bar_idx_n = bar_idx_q + 1'b1;
                end else begin
                    bar_cnt_n = bar_cnt_q + 1'b1;
                end
            end
        end
    end

    ili9341_pattern_gen #(
        .PIXEL_SIZE  (PIXEL_SIZE),
        .CHECK_SHIFT (CHECK_SHIFT),
        .X_W         (X_W),
        .Y_W         (Y_W),
        .BAR_W       (BAR_W)
    ) u_gen (
        .mode    (mode_n),
        .color   (color_n),
        .x       (x_n),
        .y       (y_n),
        .bar_idx (bar_idx_n),
        .pixel   (gen_pixel)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state         <= ST_IDLE;
            mode_q        <= MODE_SOLID;
            color_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
            valid_q       <= 1'b0;
            data_q        <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            mode_q    <= mode_n;
            color_q   <= color_n;
            x_q       <= x_n;
            y_q       <= y_n;
            bar_cnt_q <= bar_cnt_n;
            bar_idx_q <= bar_idx_n;
            if (reload || advance) begin
                data_q <= gen_pixel;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state         <= ST_RUN;
                        valid_q       <= 1'b1;
                        busy_q        <= 1'b1;
                        frame_done_q  <= 1'b0;
                        frame_start_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (!last_px) begin
                            frame_start_q <= 1'b0;
                        end else if (continuous) begin
                            // Wrap without a bubble: valid stays high into (0,0).
                            frame_start_q <= 1'b1;
                        end else begin
                            state         <= ST_DONE;
                            valid_q       <= 1'b0;
                            busy_q        <= 1'b0;
                            frame_done_q  <= 1'b1;
                            frame_start_q <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pix.pixel_valid = valid_q;
    assign pix.pixel_data  = data_q;
    assign pix.pixel_x     = x_q;
    assign pix.pixel_y     = y_q;
    assign pix.frame_start = frame_start_q;
    assign pix.frame_done  = frame_done_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_ili9341_pattern_source.sv
// ----------------------------------------------------------------------------
// tb_ili9341_pattern_source
// Self-checking bench for ili9341_pattern_source. A reduced frame height keeps
// the run short while keeping the 320-pixel line (40-pixel bars, 16-pixel tiles).
// ----------------------------------------------------------------------------
module tb_ili9341_pattern_source;

    localparam int H_RES = 320;
    localparam int V_RES = 40;
    localparam int PS    = 16;
    localparam int CS    = 4;
    localparam int BC    = 8;
    localparam int N_PIX = H_RES * V_RES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [PS-1:0] solid_color = '0;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q_data[$];
    int          q_x[$];
    int          q_y[$];
    bit          q_fs[$];

    always #5 clk = ~clk;

    ili9341_pattern_source_if #(.H_RES(H_RES), .V_RES(V_RES), .PIXEL_SIZE(PS)) pix ();

    ili9341_pattern_source #(
        .H_RES(H_RES), .V_RES(V_RES), .PIXEL_SIZE(PS), .CHECK_SHIFT(CS), .BAR_COUNT(BC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .mode        (mode),
        .solid_color (solid_color),
        .pix         (pix),
        .busy        (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] bar_ref(input int idx);
        case (idx % 8)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] exp_pixel(input int m, input logic [15:0] c,
                                              input int x, input int y);
        case (m)
            0: return c;
            1: return bar_ref(x / (H_RES / BC));
            2: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? ~c : c;
            default: return 16'(x + y);
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete(); q_x.delete(); q_y.delete(); q_fs.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; continuous = 1'b0; pix.pixel_ready = 1'b0;
        tick();
        rst = 1'b0;
        clear_q();
    endtask

    task automatic kick(input logic [1:0] m, input logic [15:0] c);
        mode = m; solid_color = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives ready (pct % of cycles) and records accepted pixels until n are taken.
    task automatic consume(input int n, input int pct, output int got, output int cycles);
        got = 0; cycles = 0;
        while (got < n && cycles < 8 * n + 64) begin
            pix.pixel_ready = ($urandom_range(99) < pct);
            if (pix.pixel_valid && pix.pixel_ready) begin
                q_data.push_back(pix.pixel_data);
                q_x.push_back(int'(pix.pixel_x));
                q_y.push_back(int'(pix.pixel_y));
                q_fs.push_back(pix.frame_start);
                got++;
            end
            tick();
            cycles++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({pix.pixel_valid, pix.pixel_data, pix.pixel_x, pix.pixel_y,
             pix.frame_start, pix.frame_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got v=%b d=%h x=%0d y=%0d fs=%b fd=%b busy=%b, want all 0",
                     pix.pixel_valid, pix.pixel_data, pix.pixel_x, pix.pixel_y,
                     pix.frame_start, pix.frame_done, busy);
        end
    endtask

    task automatic test_solid_frame();
        int got, cyc;
        kick(2'd0, 16'h07FF);
        n_checks++;
        if (!(pix.pixel_valid === 1'b1 && busy === 1'b1 && pix.frame_start === 1'b1 &&
              pix.pixel_x === '0 && pix.pixel_y === '0 && pix.pixel_data === 16'h07FF)) begin
            n_fail++;
            $display("FAIL start_latency: got v=%b busy=%b fs=%b x=%0d y=%0d d=%h, want 1 1 1 0 0 07ff",
                     pix.pixel_valid, busy, pix.frame_start, pix.pixel_x, pix.pixel_y, pix.pixel_data);
        end
        consume(N_PIX, 100, got, cyc);
        n_checks++;
        if (got != N_PIX || cyc != N_PIX) begin
            n_fail++;
            $display("FAIL solid_count: got %0d accepts in %0d cycles, want %0d in %0d",
                     got, cyc, N_PIX, N_PIX);
        end
        for (int i = 0; i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== 16'h07FF || q_x[i] != i % H_RES || q_y[i] != i / H_RES) begin
                n_fail++;
                $display("FAIL solid_pixel[%0d]: got d=%h (%0d,%0d), want d=07ff (%0d,%0d)",
                         i, q_data[i], q_x[i], q_y[i], i % H_RES, i / H_RES);
                break;
            end
        end
        // ready without valid must not disturb DONE
        pix.pixel_ready = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (!(pix.frame_done === 1'b1 && pix.pixel_valid === 1'b0 && busy === 1'b0)) begin
            n_fail++;
            $display("FAIL done_state: got fd=%b v=%b busy=%b, want 1 0 0",
                     pix.frame_done, pix.pixel_valid, busy);
        end
    endtask

    task automatic test_bars();
        int got, cyc;
        clear_q();
        kick(2'd1, 16'($urandom));
        n_checks++;
        if (!(pix.frame_done === 1'b0 && pix.pixel_valid === 1'b1 &&
              pix.pixel_x === '0 && pix.pixel_y === '0)) begin
            n_fail++;
            $display("FAIL restart_from_done: got fd=%b v=%b x=%0d y=%0d, want 0 1 0 0",
                     pix.frame_done, pix.pixel_valid, pix.pixel_x, pix.pixel_y);
        end
        consume(2 * H_RES, 100, got, cyc);
        for (int i = 0; i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== exp_pixel(1, 16'h0, i % H_RES, i / H_RES)) begin
                n_fail++;
                $display("FAIL bars_pixel(%0d,%0d): got %h, want %h", i % H_RES, i / H_RES,
                         q_data[i], exp_pixel(1, 16'h0, i % H_RES, i / H_RES));
                break;
            end
        end
        n_checks++;
        if (q_data.size() != 2 * H_RES || q_data[40] !== 16'hFFE0 || q_data[H_RES + 300] !== 16'h0000) begin
            n_fail++;
            $display("FAIL bars_spots: got n=%0d (40,0)=%h (300,1)=%h, want %0d ffe0 0000",
                     q_data.size(), q_data[40], q_data[H_RES + 300], 2 * H_RES);
        end
        do_reset();
    endtask

    task automatic test_checker_backpressure();
        int got, cyc, target, sx, sy;
        logic [15:0] sd;
        bit held;
        do_reset();
        kick(2'd2, 16'hF800);
        target = 18 * H_RES;
        got = 0; cyc = 0; held = 0; sd = '0; sx = 0; sy = 0;
        while (got < target && cyc < 8 * target) begin
            if (held) begin
                n_checks++;
                if (pix.pixel_valid !== 1'b1 || pix.pixel_data !== sd ||
                    int'(pix.pixel_x) != sx || int'(pix.pixel_y) != sy) begin
                    n_fail++;
                    $display("FAIL hold_while_stalled: got v=%b d=%h (%0d,%0d), want 1 %h (%0d,%0d)",
                             pix.pixel_valid, pix.pixel_data, pix.pixel_x, pix.pixel_y, sd, sx, sy);
                end
            end
            if (got == 1000) begin
                // mid-frame changes must wait for the next frame
                solid_color = 16'($urandom);
                mode = 2'($urandom_range(3));
            end
            pix.pixel_ready = ($urandom_range(99) < 50);
            sd = pix.pixel_data; sx = int'(pix.pixel_x); sy = int'(pix.pixel_y);
            held = pix.pixel_valid && !pix.pixel_ready;
            if (pix.pixel_valid && pix.pixel_ready) begin
                q_data.push_back(pix.pixel_data);
                got++;
            end
            tick();
            cyc++;
        end
        n_checks++;
        if (got != target) begin
            n_fail++;
            $display("FAIL checker_count: got %0d accepts, want %0d", got, target);
        end
        for (int i = 0; i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== exp_pixel(2, 16'hF800, i % H_RES, i / H_RES)) begin
                n_fail++;
                $display("FAIL checker_pixel(%0d,%0d): got %h, want %h", i % H_RES, i / H_RES,
                         q_data[i], exp_pixel(2, 16'hF800, i % H_RES, i / H_RES));
                break;
            end
        end
        n_checks++;
        if (q_data[16] !== 16'h07FF || q_data[16 * H_RES + 16] !== 16'hF800) begin
            n_fail++;
            $display("FAIL checker_spots: got (16,0)=%h (16,16)=%h, want 07ff f800",
                     q_data[16], q_data[16 * H_RES + 16]);
        end
    endtask

    task automatic test_continuous_wrap();
        int g1, c1, g2, c2, g3, c3, extra, xi, yi;
        logic [15:0] want;
        do_reset();
        extra = 1000;
        continuous = 1'b1;
        kick(2'd1, 16'($urandom));
        consume(N_PIX / 2, 100, g1, c1);
        mode = 2'd3;
        solid_color = 16'($urandom);
        continuous = 1'b0;          // toggled mid-frame: only the last accept matters
        consume(10, 100, g2, c2);
        continuous = 1'b1;
        consume(N_PIX - N_PIX / 2 - 10 + extra, 100, g3, c3);
        n_checks++;
        if (g1 + g2 + g3 != N_PIX + extra || c1 + c2 + c3 != N_PIX + extra) begin
            n_fail++;
            $display("FAIL wrap_no_gap: got %0d accepts in %0d cycles, want %0d in %0d",
                     g1 + g2 + g3, c1 + c2 + c3, N_PIX + extra, N_PIX + extra);
        end
        for (int i = 0; i < q_data.size(); i++) begin
            xi = (i % N_PIX) % H_RES;
            yi = (i % N_PIX) / H_RES;
            want = exp_pixel((i < N_PIX) ? 1 : 3, 16'h0, xi, yi);
            n_checks++;
            if (q_data[i] !== want || q_x[i] != xi || q_y[i] != yi ||
                q_fs[i] != ((i % N_PIX) == 0)) begin
                n_fail++;
                $display("FAIL wrap_pixel[%0d]: got d=%h (%0d,%0d) fs=%b, want d=%h (%0d,%0d) fs=%b",
                         i, q_data[i], q_x[i], q_y[i], q_fs[i], want, xi, yi, (i % N_PIX) == 0);
                break;
            end
        end
        n_checks++;
        if (q_data.size() != N_PIX + extra || q_data[N_PIX] !== 16'h0000 ||
            q_data[N_PIX + 3 * H_RES + 5] !== 16'h0008) begin
            n_fail++;
            $display("FAIL wrap_spots: got n=%0d (0,0)=%h (5,3)=%h, want %0d 0000 0008",
                     q_data.size(), q_data[N_PIX], q_data[N_PIX + 3 * H_RES + 5], N_PIX + extra);
        end
    endtask

    task automatic test_reset_midframe();
        int got, cyc;
        do_reset();
        kick(2'($urandom_range(3)), 16'($urandom));
        consume(30 * H_RES + 100, 100, got, cyc);
        n_checks++;
        if (!(pix.pixel_valid === 1'b1 && int'(pix.pixel_x) == 100 && int'(pix.pixel_y) == 30)) begin
            n_fail++;
            $display("FAIL midframe_position: got v=%b (%0d,%0d), want 1 (100,30)",
                     pix.pixel_valid, pix.pixel_x, pix.pixel_y);
        end
        rst = 1'b1; start = 1'b1;
        tick();
        n_checks++;
        if ({pix.pixel_valid, pix.pixel_data, pix.pixel_x, pix.pixel_y,
             pix.frame_start, pix.frame_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL rst_beats_start: got v=%b d=%h x=%0d y=%0d fs=%b fd=%b busy=%b, want all 0",
                     pix.pixel_valid, pix.pixel_data, pix.pixel_x, pix.pixel_y,
                     pix.frame_start, pix.frame_done, busy);
        end
        rst = 1'b0; start = 1'b0;
        tick();
        n_checks++;
        if (!(pix.pixel_valid === 1'b0 && busy === 1'b0 && pix.frame_done === 1'b0)) begin
            n_fail++;
            $display("FAIL idle_after_rst: got v=%b busy=%b fd=%b, want 0 0 0",
                     pix.pixel_valid, busy, pix.frame_done);
        end
    endtask

    task automatic test_start_in_run();
        int g1, c1, g2, c2, sx, sy;
        logic [15:0] c, sd;
        do_reset();
        c = 16'($urandom);
        kick(2'd2, c);
        consume(50, 100, g1, c1);
        pix.pixel_ready = 1'b0;
        sd = pix.pixel_data; sx = int'(pix.pixel_x); sy = int'(pix.pixel_y);
        for (int k = 0; k < 20; k++) begin
            start = (k == 3 || k == 10);
            mode  = 2'($urandom_range(3));
            tick();
            n_checks++;
            if (pix.pixel_valid !== 1'b1 || busy !== 1'b1 || pix.pixel_data !== sd ||
                int'(pix.pixel_x) != sx || int'(pix.pixel_y) != sy) begin
                n_fail++;
                $display("FAIL frozen_cycle%0d: got v=%b busy=%b d=%h (%0d,%0d), want 1 1 %h (%0d,%0d)",
                         k, pix.pixel_valid, busy, pix.pixel_data, pix.pixel_x, pix.pixel_y, sd, sx, sy);
            end
        end
        start = 1'b0;
        consume(N_PIX - 50, 75, g2, c2);
        n_checks++;
        if (q_data.size() != N_PIX || pix.frame_done !== 1'b1 || pix.pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_run_count: got n=%0d fd=%b v=%b, want %0d 1 0",
                     q_data.size(), pix.frame_done, pix.pixel_valid, N_PIX);
        end
        for (int i = 0; i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== exp_pixel(2, c, i % H_RES, i / H_RES) ||
                q_x[i] != i % H_RES || q_y[i] != i / H_RES) begin
                n_fail++;
                $display("FAIL start_in_run_pixel[%0d]: got d=%h (%0d,%0d), want d=%h (%0d,%0d)",
                         i, q_data[i], q_x[i], q_y[i], exp_pixel(2, c, i % H_RES, i / H_RES),
                         i % H_RES, i / H_RES);
                break;
            end
        end
    endtask

    initial begin
        pix.pixel_ready = 1'b0;
        test_reset();
        test_solid_frame();
        test_bars();
        test_checker_backpressure();
        test_continuous_wrap();
        test_reset_midframe();
        test_start_in_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
